// File: rtl/formula_res_credit_fifo.sv
// Result FIFO with credit-based issue throttling for the formula pipe.
// Buffered plus in-flight results never exceed DEPTH, so no result is lost.
module formula_res_credit_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_vld,
    output logic             up_rdy,
    output logic             issue_vld,
    input  logic             res_vld,
    input  logic [WIDTH-1:0] res,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] occupancy,
    output logic [CNT_W-1:0] in_flight,
    output logic             err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] occ_d;
    logic [CNT_W-1:0] infl_q;
    logic [CNT_W-1:0] infl_d;
    logic             err_q;
    logic             err_d;

    logic             issue;
    logic             pop;
    logic             wr;
    logic             full;
    logic             underflow;
    logic             overflow;
    logic [CNT_W:0]   used;

    // Credit check uses registered counts only, so up_rdy has no input path.
    assign used   = {1'b0, occ_q} + {1'b0, infl_q};
    assign up_rdy = (used < CREDITS);

    assign issue     = up_vld & up_rdy;
    assign issue_vld = issue;

    assign full = (occ_q == FULL_CNT);
    assign wr   = res_vld & ~full;

    assign out_vld  = (occ_q != '0);
    assign out_data = mem[rd_ptr];
    assign pop      = out_vld & out_rdy;

    // A result with nothing outstanding (and no same-cycle issue) is bogus.
    assign underflow = res_vld & ~issue & (infl_q == '0);
    // A result arriving into a full FIFO is dropped.
    assign overflow  = res_vld & full;

    assign occupancy = occ_q;
    assign in_flight = infl_q;
    assign err       = err_q;

    // Outstanding-result count: +1 on issue, -1 on return, floor at zero.
    always_comb begin
        infl_d = infl_q;
        unique case ({issue, res_vld})
            2'b10: infl_d = infl_q + CNT_W'(1);
            2'b01: begin
                if (infl_q != '0) begin
                    infl_d = infl_q - CNT_W'(1);
                end
            end
            default: infl_d = infl_q;
        endcase
    end

    // Stored-entry count: +1 on accepted write, -1 on pop.
    always_comb begin
        occ_d = occ_q;
        unique case ({wr, pop})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Error flag is sticky until reset.
    always_comb begin
        err_d = err_q | underflow | overflow;
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= res;
        end
    end

    // Pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Counter and error state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= '0;
            infl_q <= '0;
            err_q  <= 1'b0;
        end else begin
            occ_q  <= occ_d;
            infl_q <= infl_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_formula_res_credit_fifo.sv
// Bench for formula_res_credit_fifo with a 3-stage delay-line pipe model.
// Issued args push arg+1 into a queue; a negedge monitor checks pops.
module tb_formula_res_credit_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             up_vld = 1'b0;
    logic             up_rdy;
    logic             issue_vld;
    logic             res_vld;
    logic [WIDTH-1:0] res;
    logic             out_vld;
    logic             out_rdy = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W-1:0] in_flight;
    logic             err;

    logic [WIDTH-1:0] up_arg = '0;
    logic             inj_vld = 1'b0;
    logic [WIDTH-1:0] inj_data = '0;
    logic [2:0]       pv;
    logic [WIDTH-1:0] pd [3];

    logic [WIDTH-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issue_cnt = 0;
    int first_out = -1;
    int max_occ = 0;
    bit track = 1'b0;
    bit hold_prev = 1'b0;
    logic [WIDTH-1:0] held = '0;

    always #5 clk = ~clk;

    formula_res_credit_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .up_vld(up_vld),
        .up_rdy(up_rdy),
        .issue_vld(issue_vld),
        .res_vld(res_vld),
        .res(res),
        .out_vld(out_vld),
        .out_rdy(out_rdy),
        .out_data(out_data),
        .occupancy(occupancy),
        .in_flight(in_flight),
        .err(err)
    );

    // Pipe model: 3-cycle delay, res = arg + 1, cleared by the shared reset.
    always @(posedge clk) begin
        if (rst) pv <= '0;
        else pv <= {pv[1:0], issue_vld};
        pd[0] <= up_arg + 1;
        pd[1] <= pd[0];
        pd[2] <= pd[1];
    end
    assign res_vld = pv[2] | inj_vld;
    assign res = inj_vld ? inj_data : pd[2];

    always @(posedge clk) begin
        cyc++;
        if (!rst && issue_vld) issue_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: compare each pop against the scoreboard, and held data.
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev && out_vld) check("hold_stable", out_data, held);
            if (out_vld && out_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got %0h, expected no output", out_data);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
            end
            hold_prev = out_vld && !out_rdy;
            held = out_data;
            if (track) begin
                if (out_vld && first_out < 0) first_out = cyc;
                if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] a, output int waited, output int icyc);
        int n = 0;
        up_vld = 1'b1;
        up_arg = a;
        while (!up_rdy && n < 50) begin
            tick();
            n++;
        end
        check("send_credit_timeout", 32'(up_rdy), 1);
        waited = n;
        icyc = cyc;
        if (up_rdy) exp_q.push_back(a + 1);
        tick();
        up_vld = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        out_rdy = 1'b1;
        while (!(exp_q.size() == 0 && occupancy == 0 && in_flight == 0) && n < 200) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size() == 0 && occupancy == 0 && in_flight == 0), 1);
    endtask

    task automatic wait_state(input string name, input int occ, input int infl);
        int n = 0;
        while (!(int'(occupancy) == occ && int'(in_flight) == infl) && n < 50) begin
            tick();
            n++;
        end
        check(name, 32'(int'(occupancy) == occ && int'(in_flight) == infl), 1);
    endtask

    initial begin
        int w;
        int c;
        int first_iss;

        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_vld", 32'(out_vld), 0);
        check("rst_occupancy", 32'(occupancy), 0);
        check("rst_in_flight", 32'(in_flight), 0);
        check("rst_err", 32'(err), 0);
        check("rst_up_rdy", 32'(up_rdy), 1);

        // Streaming with consumer always ready
        out_rdy = 1'b1;
        first_out = -1;
        max_occ = 0;
        issue_cnt = 0;
        first_iss = 0;
        track = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(32'(10 + i), w, c);
            if (i == 0) first_iss = c;
        end
        drain("stream_drain");
        track = 1'b0;
        check("stream_latency", 32'(first_out - first_iss), 4);
        check("stream_max_occ", 32'(max_occ <= 1), 1);
        check("stream_issues", 32'(issue_cnt), 8);

        // Backpressure: credits stop issue at DEPTH
        out_rdy = 1'b0;
        issue_cnt = 0;
        for (int i = 0; i < 4; i++) send(32'(i), w, c);
        up_vld = 1'b1;
        up_arg = 32'd4;
        repeat (8) tick();
        check("bp_issues", 32'(issue_cnt), 4);
        check("bp_up_rdy", 32'(up_rdy), 0);
        check("bp_occupancy", 32'(occupancy), 4);
        check("bp_in_flight", 32'(in_flight), 0);
        check("bp_err", 32'(err), 0);
        out_rdy = 1'b1;
        send(32'd4, w, c);
        check("bp_first_credit_wait", 32'(w), 1);
        for (int i = 5; i < 8; i++) begin
            send(32'(i), w, c);
            check("bp_credit_wait", 32'(w), 0);
        end
        drain("bp_drain");

        // Simultaneous write and pop at occupancy 2
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) send(32'(20 + i), w, c);
        wait_state("sim_setup", 2, 1);
        out_rdy = 1'b1;
        tick();
        check("sim_occupancy", 32'(occupancy), 2);
        drain("sim_drain");

        // Wraparound with a ragged consumer
        for (int i = 0; i < 20; i++) begin
            out_rdy = (i % 3 != 0);
            send(32'(100 + i), w, c);
        end
        drain("wrap_drain");

        // Spurious result with nothing in flight
        out_rdy = 1'b0;
        inj_data = 32'hDEAD_BEEF;
        inj_vld = 1'b1;
        exp_q.push_back(inj_data);
        tick();
        inj_vld = 1'b0;
        check("err_set", 32'(err), 1);
        check("err_in_flight", 32'(in_flight), 0);
        check("err_written", 32'(occupancy), 1);
        out_rdy = 1'b1;
        repeat (3) tick();
        check("err_sticky", 32'(err), 1);
        check("err_popped", 32'(exp_q.size()), 0);

        // Mid-operation reset
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) send(32'(30 + i), w, c);
        wait_state("mid_setup", 3, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("mid_occupancy", 32'(occupancy), 0);
        check("mid_in_flight", 32'(in_flight), 0);
        check("mid_out_vld", 32'(out_vld), 0);
        check("mid_up_rdy", 32'(up_rdy), 1);
        check("mid_err", 32'(err), 0);
        repeat (5) tick();
        check("mid_err_later", 32'(err), 0);
        check("mid_occ_later", 32'(occupancy), 0);

        // Traffic still flows after the reset
        out_rdy = 1'b1;
        send(32'd50, w, c);
        send(32'd51, w, c);
        drain("post_rst_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
